seq_muldiv: RTL and testbench
=============================

# seq_muldiv

Multi-cycle signed multiply/divide unit for the CPU datapath, sitting directly downstream of the bus mux. Operand A comes from the Y register and operand B from the bus output; the 64-bit result is produced for the Z register pair, which feeds back into the bus as the Zhigh and Zlow sources. Multiplication uses radix-2 Booth. Division uses signed restoring division. Each operation takes a fixed 32 iteration cycles under a start/busy/done handshake.

## Interface
Parameters:
- wordSize, 32, operand width. The iteration count equals wordSize.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-high.
- start  input  1  single-cycle request. Sampled only in IDLE.
- op  input  1  0 = MUL, 1 = DIV. Captured with start.
- a_in  input  wordSize  multiplicand or dividend (from Y). Signed.
- b_in  input  wordSize  multiplier or divisor (from BusMuxOut). Signed.
- z_high  output  wordSize  MUL: product [63:32]; DIV: remainder.
- z_low  output  wordSize  MUL: product [31:0]; DIV: quotient.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- div_by_zero  output  1  set with done when a DIV had b_in == 0; cleared on next accepted start.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1:
  - Latch op, a_in, b_in.
  - Clear div_by_zero.
  - Counter <= 0.
  - Go to RUN, except DIV with b_in == 0, which goes to FIN.
- RUN: one iteration per cycle. After iteration wordSize-1 (counter == wordSize-1), go to FIN.
- FIN: done=1 and results are written to z_high/z_low in the same cycle. Next state is IDLE.
- MUL:
  - Booth radix-2 on {A, Q, Q-1}.
  - Arithmetic right shift of the (2·wordSize+1)-bit accumulator each step.
  - Result is the exact signed 64-bit product.
- DIV:
  - Operate on magnitudes, then fix signs in FIN.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - -2^31 / -1: quotient 32'h80000000, remainder 0 (wraps, no flag).
- Divide by zero: z_low = 32'hFFFFFFFF, z_high = a_in, div_by_zero = 1.
- z_high/z_low hold their values until the next FIN. They do not change during RUN.
- start while busy or in FIN is ignored; no queueing.
- Operand inputs are don't-care after the capture cycle.

## Timing
- Reset values: z_high=0, z_low=0, busy=0, done=0, div_by_zero=0, state IDLE.
- Capture edge is T (start high in the preceding cycle).
- busy is high from cycle T+1 through the FIN cycle, inclusive.
- Normal latency: RUN occupies cycles T+1..T+32; FIN and done in cycle T+33; IDLE at T+34.
- Divide-by-zero latency: FIN and done in cycle T+1.
- A new start is accepted at the earliest in cycle T+34, i.e. the first IDLE cycle.
- start and clr in the same cycle: clr wins.
- clr mid-operation: next edge is IDLE with all outputs at their reset values, and no done pulse. A partial result is never exposed.
- done never asserts outside FIN. done is never high on two consecutive cycles.

## Configuration
- Macro: SEQ_MULDIV_DIV_EN.
  - Defined: full behaviour as above.
  - Undefined: divider datapath is omitted, and op=1 goes straight to FIN with z_high=0, z_low=0, div_by_zero=0 and done at T+1. MUL is unaffected.

## Structure
- Shared package cpu_pkg holds:
  - op encodings OP_MUL and OP_DIV.
  - FSM state typedef muldiv_state_t.
  - Constant MULDIV_ITER = 32.
- One sub-module, booth_step: combinational single Booth iteration (add/sub/none, then arithmetic shift). Instantiated once by seq_muldiv.
- Division step, counter and FSM live in seq_muldiv.

## Test plan
- MUL 6 × -7 -> done at T+33; z_high=FFFFFFFF, z_low=FFFFFFD6; busy high for exactly 33 cycles.
- MUL 80000000 × 80000000 -> z_high=40000000, z_low=00000000.
- DIV -7 / 2 -> z_low=FFFFFFFD, z_high=FFFFFFFF, div_by_zero=0.
- DIV 7 / 0 -> done at T+1; z_low=FFFFFFFF, z_high=00000007, div_by_zero=1.
  - A following MUL 2×3 -> div_by_zero=0, z_low=6.
- DIV 80000000 / FFFFFFFF -> z_low=80000000, z_high=0. With SEQ_MULDIV_DIV_EN undefined -> zeros with done at T+1.
- Start MUL 3×5, pulse start again at T+10 and assert clr at T+20 -> second start ignored; all outputs 0 at T+21; no done pulse.
  - A new MUL 3×5 started afterwards -> z_low=0000000F.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: multiply/divide op encodings, FSM states
// and the default iteration count for seq_muldiv.
package cpu_pkg;

  localparam int MULDIV_ITER = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/seq_muldiv_booth_step.sv
// One radix-2 Booth iteration: add/subtract/hold the multiplicand into the
// upper accumulator, then arithmetic-shift {A, Q, Q-1} right by one.
module booth_step #(
  parameter int W = 32
) (
  input  logic signed [W:0]   acc_hi_i,
  input  logic        [W-1:0] acc_lo_i,
  input  logic                qm1_i,
  input  logic        [W-1:0] mcand_i,
  output logic signed [W:0]   acc_hi_o,
  output logic        [W-1:0] acc_lo_o,
  output logic                qm1_o
);

  // A carries one guard bit so subtracting -2^(W-1) cannot overflow the sign.
  logic signed [W:0] m_ext;
  logic signed [W:0] sum;

  assign m_ext = {mcand_i[W-1], mcand_i};

  always_comb begin
    sum = acc_hi_i;
    unique case ({acc_lo_i[0], qm1_i})
      2'b01:   sum = acc_hi_i + m_ext;
      2'b10:   sum = acc_hi_i - m_ext;
      default: sum = acc_hi_i;
    endcase
    {acc_hi_o, acc_lo_o, qm1_o} = {sum[W], sum, acc_lo_i};
  end

endmodule

// File: rtl/seq_muldiv.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit.
// Define SEQ_MULDIV_DIV_EN to build the divider; otherwise DIV returns zeros.
module seq_muldiv
  import cpu_pkg::*;
#(
  parameter int wordSize = MULDIV_ITER
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                op,
  input  logic [wordSize-1:0] a_in,
  input  logic [wordSize-1:0] b_in,
  output logic [wordSize-1:0] z_high,
  output logic [wordSize-1:0] z_low,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero
);

  localparam int CW = $clog2(wordSize);

  muldiv_state_t              state_q;
  logic [CW-1:0]              cnt_q;
  logic signed [wordSize:0]   hi_q;
  logic [wordSize-1:0]        lo_q;
  logic [wordSize-1:0]        m_q;
  logic                       qm1_q;
  logic [wordSize-1:0]        z_high_q, z_low_q;
  logic                       busy_q, done_q, dbz_q;

  logic signed [wordSize:0]   bth_hi;
  logic [wordSize-1:0]        bth_lo;
  logic                       bth_qm1;
  logic signed [wordSize:0]   step_hi_d;
  logic [wordSize-1:0]        step_lo_d;
  logic                       step_qm1_d;
  logic [wordSize-1:0]        res_hi_d, res_lo_d;

  booth_step #(.W(wordSize)) u_booth (
    .acc_hi_i (hi_q),
    .acc_lo_i (lo_q),
    .qm1_i    (qm1_q),
    .mcand_i  (m_q),
    .acc_hi_o (bth_hi),
    .acc_lo_o (bth_lo),
    .qm1_o    (bth_qm1)
  );

`ifdef SEQ_MULDIV_DIV_EN
  logic                op_q;
  logic                neg_quo_q, neg_rem_q;
  logic [wordSize:0]   div_shift, div_diff;

  function automatic logic [wordSize-1:0] mag(input logic [wordSize-1:0] v);
    return v[wordSize-1] ? -v : v;
  endfunction

  // Restoring step on magnitudes: remainder in hi_q, dividend/quotient in lo_q.
  always_comb begin
    div_shift = {hi_q[wordSize-1:0], lo_q[wordSize-1]};
    div_diff  = div_shift - {1'b0, m_q};
  end
`endif

  always_comb begin
    step_hi_d  = bth_hi;
    step_lo_d  = bth_lo;
    step_qm1_d = bth_qm1;
`ifdef SEQ_MULDIV_DIV_EN
    if (op_q == OP_DIV) begin
      step_hi_d  = div_diff[wordSize] ? div_shift : div_diff;
      step_lo_d  = {lo_q[wordSize-2:0], ~div_diff[wordSize]};
      step_qm1_d = 1'b0;
    end
`endif
    res_hi_d = step_hi_d[wordSize-1:0];
    res_lo_d = step_lo_d;
`ifdef SEQ_MULDIV_DIV_EN
    if (op_q == OP_DIV) begin
      res_lo_d = neg_quo_q ? -step_lo_d : step_lo_d;
      res_hi_d = neg_rem_q ? -step_hi_d[wordSize-1:0] : step_hi_d[wordSize-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      z_high_q <= '0;
      z_low_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= b_in;
            m_q     <= a_in;
            qm1_q   <= 1'b0;
            state_q <= RUN;
`ifdef SEQ_MULDIV_DIV_EN
            op_q <= op;
            if (op == OP_DIV) begin
              lo_q      <= mag(a_in);
              m_q       <= mag(b_in);
              neg_quo_q <= a_in[wordSize-1] ^ b_in[wordSize-1];
              neg_rem_q <= a_in[wordSize-1];
              if (b_in == '0) begin
                state_q  <= FIN;
                done_q   <= 1'b1;
                dbz_q    <= 1'b1;
                z_high_q <= a_in;
                z_low_q  <= '1;
              end
            end
`else
            if (op == OP_DIV) begin
              state_q  <= FIN;
              done_q   <= 1'b1;
              z_high_q <= '0;
              z_low_q  <= '0;
            end
`endif
          end
        end
        RUN: begin
          hi_q  <= step_hi_d;
          lo_q  <= step_lo_d;
          qm1_q <= step_qm1_d;
          cnt_q <= cnt_q + CW'(1);
          // Results land on the same edge that enters FIN, so done and data align.
          if (cnt_q == CW'(wordSize - 1)) begin
            state_q  <= FIN;
            done_q   <= 1'b1;
            z_high_q <= res_hi_d;
            z_low_q  <= res_lo_d;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign z_high      = z_high_q;
  assign z_low       = z_low_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv: scoreboard of expected results,
// one task per scenario, inline comparisons.
module tb_seq_muldiv;
  import cpu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr, start, op;
  logic [W-1:0] a_in, b_in;
  logic [W-1:0] z_high, z_low;
  logic         busy, done, div_by_zero;

  seq_muldiv #(.wordSize(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .z_high      (z_high),
    .z_low       (z_low),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  typedef struct {
    int           lat;
    int           bcnt;
    logic         zchg;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    logic         after_ok;
  } obs_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [2*W-1:0] p;
    e.dbz = 1'b0;
    e.lat = 33;
    if (o == OP_MUL) begin
      p    = $signed(a) * $signed(b);
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else begin
`ifdef SEQ_MULDIV_DIV_EN
      if (b == '0) begin
        e.hi = a; e.lo = '1; e.dbz = 1'b1; e.lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.hi = '0; e.lo = 32'h8000_0000;
      end else begin
        e.lo = $signed(a) / $signed(b);
        e.hi = $signed(a) % $signed(b);
      end
`else
      e.hi = '0; e.lo = '0; e.lat = 1;
`endif
    end
    return e;
  endfunction

  // Caller is positioned at a negedge with the DUT idle; returns at the negedge after FIN.
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, output obs_t ob);
    logic [W-1:0] hi0, lo0;
    sb.push_back(model(o, a, b));
    hi0 = z_high; lo0 = z_low;
    ob.lat = -1; ob.bcnt = 0; ob.zchg = 1'b0;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = $urandom_range(1, 0); a_in = $urandom; b_in = $urandom;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (busy) ob.bcnt++;
      if (done) begin
        ob.lat = n;
        break;
      end
      if (z_high !== hi0 || z_low !== lo0) ob.zchg = 1'b1;
    end
    ob.hi = z_high; ob.lo = z_low; ob.dbz = div_by_zero;
    @(negedge clk);
    ob.after_ok = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; op = OP_MUL; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    n_checks++; if (z_high !== '0) $display("FAIL reset_z_high: got %h want 0", z_high); else n_pass++;
    n_checks++; if (z_low !== '0) $display("FAIL reset_z_low: got %h want 0", z_low); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b want 0", div_by_zero); else n_pass++;
  endtask

  task automatic test_mul();
    logic [W-1:0] ta[8], tb_[8];
    obs_t ob; exp_t e;
    ta[0] = 32'd6;         tb_[0] = -32'sd7;
    ta[1] = 32'h8000_0000; tb_[1] = 32'h8000_0000;
    ta[2] = 32'hFFFF_FFFF; tb_[2] = 32'hFFFF_FFFF;
    ta[3] = 32'h7FFF_FFFF; tb_[3] = 32'h8000_0000;
    for (int i = 4; i < 8; i++) begin ta[i] = $urandom; tb_[i] = $urandom; end
    for (int i = 0; i < 8; i++) begin
      run_op(OP_MUL, ta[i], tb_[i], ob);
      e = sb.pop_front();
      n_checks++; if (ob.lat !== e.lat) $display("FAIL mul_latency[%0d]: got %0d want %0d", i, ob.lat, e.lat); else n_pass++;
      n_checks++; if (ob.bcnt !== e.lat) $display("FAIL mul_busy_cycles[%0d]: got %0d want %0d", i, ob.bcnt, e.lat); else n_pass++;
      n_checks++; if (ob.hi !== e.hi) $display("FAIL mul_z_high[%0d]: got %h want %h", i, ob.hi, e.hi); else n_pass++;
      n_checks++; if (ob.lo !== e.lo) $display("FAIL mul_z_low[%0d]: got %h want %h", i, ob.lo, e.lo); else n_pass++;
      n_checks++; if (ob.dbz !== e.dbz) $display("FAIL mul_dbz[%0d]: got %b want %b", i, ob.dbz, e.dbz); else n_pass++;
      n_checks++; if (ob.zchg !== 1'b0) $display("FAIL mul_z_stable[%0d]: got changed=%b want 0", i, ob.zchg); else n_pass++;
      n_checks++; if (ob.after_ok !== 1'b1) $display("FAIL mul_after_fin[%0d]: got ok=%b want 1", i, ob.after_ok); else n_pass++;
    end
  endtask

  task automatic test_div();
    logic [W-1:0] ta[8], tb_[8];
    obs_t ob; exp_t e;
    ta[0] = -32'sd7;       tb_[0] = 32'd2;
    ta[1] = 32'h8000_0000; tb_[1] = 32'hFFFF_FFFF;
    ta[2] = 32'd7;         tb_[2] = -32'sd2;
    ta[3] = 32'h8000_0000; tb_[3] = 32'd3;
    for (int i = 4; i < 8; i++) begin
      ta[i] = $urandom; tb_[i] = $urandom_range(65535, 1);
      if (i[0]) tb_[i] = -tb_[i];
    end
    for (int i = 0; i < 8; i++) begin
      run_op(OP_DIV, ta[i], tb_[i], ob);
      e = sb.pop_front();
      n_checks++; if (ob.lat !== e.lat) $display("FAIL div_latency[%0d]: got %0d want %0d", i, ob.lat, e.lat); else n_pass++;
      n_checks++; if (ob.hi !== e.hi) $display("FAIL div_z_high[%0d]: got %h want %h", i, ob.hi, e.hi); else n_pass++;
      n_checks++; if (ob.lo !== e.lo) $display("FAIL div_z_low[%0d]: got %h want %h", i, ob.lo, e.lo); else n_pass++;
      n_checks++; if (ob.dbz !== e.dbz) $display("FAIL div_dbz[%0d]: got %b want %b", i, ob.dbz, e.dbz); else n_pass++;
      n_checks++; if (ob.after_ok !== 1'b1) $display("FAIL div_after_fin[%0d]: got ok=%b want 1", i, ob.after_ok); else n_pass++;
    end
  endtask

  task automatic test_div_by_zero();
    obs_t ob; exp_t e;
    run_op(OP_DIV, 32'd7, 32'd0, ob);
    e = sb.pop_front();
    n_checks++; if (ob.lat !== e.lat) $display("FAIL dbz_latency: got %0d want %0d", ob.lat, e.lat); else n_pass++;
    n_checks++; if (ob.bcnt !== e.lat) $display("FAIL dbz_busy_cycles: got %0d want %0d", ob.bcnt, e.lat); else n_pass++;
    n_checks++; if (ob.hi !== e.hi) $display("FAIL dbz_z_high: got %h want %h", ob.hi, e.hi); else n_pass++;
    n_checks++; if (ob.lo !== e.lo) $display("FAIL dbz_z_low: got %h want %h", ob.lo, e.lo); else n_pass++;
    n_checks++; if (ob.dbz !== e.dbz) $display("FAIL dbz_flag: got %b want %b", ob.dbz, e.dbz); else n_pass++;
    n_checks++; if (ob.after_ok !== 1'b1) $display("FAIL dbz_after_fin: got ok=%b want 1", ob.after_ok); else n_pass++;
    run_op(OP_MUL, 32'd2, 32'd3, ob);
    e = sb.pop_front();
    n_checks++; if (ob.dbz !== 1'b0) $display("FAIL dbz_cleared: got %b want 0", ob.dbz); else n_pass++;
    n_checks++; if (ob.lo !== e.lo) $display("FAIL dbz_next_mul_z_low: got %h want %h", ob.lo, e.lo); else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t ob; exp_t e;
    logic o;
    for (int i = 0; i < 4; i++) begin
      o = i[0] ? OP_DIV : OP_MUL;
      run_op(o, $urandom, $urandom_range(1000, 1), ob);
      e = sb.pop_front();
      n_checks++; if (ob.lat !== e.lat) $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, ob.lat, e.lat); else n_pass++;
      n_checks++; if (ob.hi !== e.hi) $display("FAIL b2b_z_high[%0d]: got %h want %h", i, ob.hi, e.hi); else n_pass++;
      n_checks++; if (ob.lo !== e.lo) $display("FAIL b2b_z_low[%0d]: got %h want %h", i, ob.lo, e.lo); else n_pass++;
    end
  endtask

  task automatic test_clr_abort();
    obs_t ob; exp_t e;
    logic saw_done, busy_at20, idle_bad;
    saw_done = 1'b0; busy_at20 = 1'b0; idle_bad = 1'b0;
    start = 1'b1; op = OP_MUL; a_in = 32'd3; b_in = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      start = (n == 10);
      if (n == 10) begin a_in = 32'd7; b_in = 32'd9; end
      if (n == 20) begin busy_at20 = busy; clr = 1'b1; end
    end
    @(negedge clk);
    clr = 1'b0;
    if (done) saw_done = 1'b1;
    n_checks++; if (busy_at20 !== 1'b1) $display("FAIL abort_busy_before_clr: got %b want 1", busy_at20); else n_pass++;
    n_checks++; if (z_high !== '0) $display("FAIL abort_z_high: got %h want 0", z_high); else n_pass++;
    n_checks++; if (z_low !== '0) $display("FAIL abort_z_low: got %h want 0", z_low); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL abort_dbz: got %b want 0", div_by_zero); else n_pass++;
    n_checks++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", saw_done); else n_pass++;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy || done) idle_bad = 1'b1;
    end
    n_checks++; if (idle_bad !== 1'b0) $display("FAIL abort_second_start_ignored: got %b want 0", idle_bad); else n_pass++;
    run_op(OP_MUL, 32'd3, 32'd5, ob);
    e = sb.pop_front();
    n_checks++; if (ob.lo !== e.lo) $display("FAIL abort_restart_z_low: got %h want %h", ob.lo, e.lo); else n_pass++;
    n_checks++; if (ob.lat !== e.lat) $display("FAIL abort_restart_latency: got %0d want %0d", ob.lat, e.lat); else n_pass++;
  endtask

  task automatic test_start_clr();
    logic bad;
    bad = 1'b0;
    start = 1'b1; clr = 1'b1; op = OP_MUL; a_in = 32'd4; b_in = 32'd4;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (busy || done) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL start_clr_same_cycle: got started=%b want 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_clr_abort();
    test_start_clr();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
